// File: rtl/decoder_ctrl_pkg.sv
// Shared types and constants for the 74138 chip-select arbiter.
package decoder_ctrl_pkg;

  localparam int ADDR_W  = 3;
  localparam int NUM_OUT = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  typedef struct packed {
    logic g1;
    logic g2a_n;
    logic g2b_n;
  } en_pins_t;

  localparam en_pins_t EN_OFF = '{g1: 1'b0, g2a_n: 1'b1, g2b_n: 1'b1};
  localparam en_pins_t EN_ON  = '{g1: 1'b1, g2a_n: 1'b0, g2b_n: 1'b0};

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/decoder_cs_arbiter_if.sv
// Requester-side bus plus decoder pin bundle for decoder_cs_arbiter.
interface decoder_cs_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import decoder_ctrl_pkg::*;

  // req_i is a level request (valid) held with its addr_i slice; grant_o is the
  // acceptance and done_o pulses once per access; the access runs to completion
  // regardless of what req_i/addr_i do after the grant.
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*ADDR_W-1:0] addr_i;
  logic [NUM_REQ-1:0]        grant_o;
  logic [NUM_REQ-1:0]        done_o;
  logic                      busy_o;
  logic                      select_a_o;
  logic                      select_b_o;
  logic                      select_c_o;
  logic                      g1_en_o;
  logic                      g2a_en_n_o;
  logic                      g2b_en_n_o;

  modport slave (
    input  req_i, addr_i,
    output grant_o, done_o, busy_o, select_a_o, select_b_o, select_c_o,
           g1_en_o, g2a_en_n_o, g2b_en_n_o
  );

  modport master (
    output req_i, addr_i,
    input  grant_o, done_o, busy_o, select_a_o, select_b_o, select_c_o,
           g1_en_o, g2a_en_n_o, g2b_en_n_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/decoder_cs_arbiter.sv
// Round-robin owner of a shared 3-to-8 decoder with setup/active/recover timing.
module decoder_cs_arbiter
  import decoder_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 4,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  decoder_cs_arbiter_if.slave  bus,
  output state_t               state_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(max3(SETUP_CYCLES, HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [ADDR_W-1:0]    sel_q, sel_d;
  en_pins_t             en_q, en_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic                 arb_valid;
  logic [PTR_W-1:0]     win_idx;
  logic [ADDR_W-1:0]    win_addr;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req   (bus.req_i),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_grant[k]) begin
        win_idx  = PTR_W'(k);
        win_addr = bus.addr_i[k*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LOAD;
          grant_d = arb_grant;
          sel_d   = win_addr;
          ptr_d   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_ACTIVE;
          cnt_d   = HOLD_LOAD;
        end else cnt_d = cnt_q - 1'b1;
      end
      ST_ACTIVE: begin
        if (cnt_q == '0) begin
          state_d = ST_RECOVER;
          cnt_d   = GAP_LOAD;
        end else cnt_d = cnt_q - 1'b1;
      end
      ST_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          grant_d = '0;
        end else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are derived from the next state so they register alongside it.
    en_d   = (state_d == ST_ACTIVE) ? EN_ON : EN_OFF;
    done_d = (state_d == ST_ACTIVE && cnt_d == '0) ? grant_d : '0;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      sel_q   <= '0;
      en_q    <= EN_OFF;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant_o    = grant_q;
  assign bus.done_o     = done_q;
  assign bus.busy_o     = busy_q;
  assign bus.select_a_o = sel_q[0];
  assign bus.select_b_o = sel_q[1];
  assign bus.select_c_o = sel_q[2];
  assign bus.g1_en_o    = en_q.g1;
  assign bus.g2a_en_n_o = en_q.g2a_n;
  assign bus.g2b_en_n_o = en_q.g2b_n;
  assign state_o        = state_q;

endmodule

// File: tb/tb_decoder_cs_arbiter.sv
// Self-checking bench for decoder_cs_arbiter: scenario tasks plus a done_o scoreboard.
module tb_decoder_cs_arbiter;
  import decoder_ctrl_pkg::*;

  localparam int NREQ  = 4;
  localparam int SETUP = 1;
  localparam int HOLD  = 4;
  localparam int GAP   = 1;
  localparam int W     = 6;

  logic   clk;
  logic   rst_n;
  state_t state;
  int     errors;
  int     checks;
  logic [W-1:0] exp_q[$];

  decoder_cs_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  decoder_cs_arbiter #(
    .NUM_REQ(NREQ), .SETUP_CYCLES(SETUP), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus),
    .state_o (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [2:0] sel_now();
    return {bus.select_c_o, bus.select_b_o, bus.select_a_o};
  endfunction

  // scoreboard / protocol monitor, sampled on the falling edge
  logic         prev_en;
  logic         prev_done;
  logic [2:0]   prev_sel;
  int           win_len;
  logic [W-1:0] e;
  logic [NREQ-1:0] exp_oh;

  initial begin
    prev_en = 1'b0; prev_done = 1'b0; prev_sel = '0; win_len = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 1'b0; prev_done = 1'b0; win_len = 0;
    end else begin
      checks++;
      if (bus.g2a_en_n_o !== ~bus.g1_en_o || bus.g2b_en_n_o !== ~bus.g1_en_o) begin
        errors++;
        $display("FAIL en_pins: g1=%b g2a_n=%b g2b_n=%b, required g2a_n=g2b_n=~g1",
                 bus.g1_en_o, bus.g2a_en_n_o, bus.g2b_en_n_o);
      end
      if (bus.g1_en_o && prev_en) begin
        checks++;
        if (sel_now() !== prev_sel) begin
          errors++;
          $display("FAIL sel_stable: select=%0d while enabled, required %0d", sel_now(), prev_sel);
        end
      end
      if (bus.g1_en_o) win_len++;
      else if (prev_en) begin
        checks++;
        if (win_len != HOLD) begin
          errors++;
          $display("FAIL hold_len: enable window %0d cycles, required %0d", win_len, HOLD);
        end
        win_len = 0;
      end
      if (bus.done_o !== '0) begin
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_pulse: done_o high two cycles running, got %b", bus.done_o);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: done_o=%b, required no completion", bus.done_o);
        end else begin
          e = exp_q.pop_front();
          exp_oh = NREQ'(1) << e[5:3];
          if (bus.done_o !== exp_oh || bus.grant_o !== exp_oh || sel_now() !== e[2:0]
              || bus.g1_en_o !== 1'b1) begin
            errors++;
            $display("FAIL done_match: done=%b grant=%b sel=%0d g1=%b, required done=grant=%b sel=%0d g1=1",
                     bus.done_o, bus.grant_o, sel_now(), bus.g1_en_o, exp_oh, e[2:0]);
          end
        end
      end
      prev_en   = bus.g1_en_o;
      prev_done = (bus.done_o !== '0);
      prev_sel  = sel_now();
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_i = '0;
    bus.addr_i = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic set_addr(input int k, input logic [2:0] a);
    bus.addr_i[k*3 +: 3] = a;
  endtask

  task automatic wait_en(input logic level, output int n);
    n = 0;
    while (bus.g1_en_o !== level && n < 100) begin tick(); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL wait_en: g1_en_o never became %b", level);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy_o !== 1'b0 || exp_q.size() != 0) && n < 500) begin tick(); n++; end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL wait_idle: busy=%b pending=%0d after %0d cycles, required idle", bus.busy_o, exp_q.size(), n);
    end
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin tick(); n++; end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL wait_drained: %0d accesses still pending", exp_q.size());
    end
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.grant_o !== '0 || bus.done_o !== '0 || bus.busy_o !== 1'b0 || state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_ctrl: grant=%b done=%b busy=%b state=%0d, required 0/0/0/IDLE",
               bus.grant_o, bus.done_o, bus.busy_o, state);
    end
    checks++;
    if (sel_now() !== 3'd0 || bus.g1_en_o !== 1'b0 || bus.g2a_en_n_o !== 1'b1 || bus.g2b_en_n_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_pins: sel=%0d g1=%b g2a_n=%b g2b_n=%b, required 0/0/1/1",
               sel_now(), bus.g1_en_o, bus.g2a_en_n_o, bus.g2b_en_n_o);
    end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    set_addr(0, 3'd5);
    bus.req_i = 4'b0001;
    exp_q.push_back({3'd0, 3'd5});
    tick();
    checks++;
    if (bus.grant_o !== 4'b0001 || sel_now() !== 3'd5 || bus.g1_en_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: grant=%b sel=%0d g1=%b busy=%b, required 0001/5/0/1",
               bus.grant_o, sel_now(), bus.g1_en_o, bus.busy_o);
    end
    bus.req_i = '0;
    wait_en(1'b1, n);
    checks++;
    if (n != SETUP) begin
      errors++;
      $display("FAIL setup_latency: enable after %0d edges from grant, required %0d", n, SETUP);
    end
    wait_en(1'b0, n);
    checks++;
    if (bus.grant_o !== 4'b0001 || bus.busy_o !== 1'b1 || sel_now() !== 3'd5) begin
      errors++;
      $display("FAIL recover_hold: grant=%b busy=%b sel=%0d, required 0001/1/5", bus.grant_o, bus.busy_o, sel_now());
    end
    repeat (GAP) tick();
    checks++;
    if (bus.grant_o !== '0 || bus.busy_o !== 1'b0 || sel_now() !== 3'd5) begin
      errors++;
      $display("FAIL single_release: grant=%b busy=%b sel=%0d, required 0000/0/5", bus.grant_o, bus.busy_o, sel_now());
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < NREQ; k++) set_addr(k, 3'(k));
    exp_q.push_back({3'd0, 3'd0});
    exp_q.push_back({3'd1, 3'd1});
    exp_q.push_back({3'd2, 3'd2});
    exp_q.push_back({3'd3, 3'd3});
    exp_q.push_back({3'd0, 3'd0});
    bus.req_i = 4'b1111;
    wait_drained();
    bus.req_i = '0;
    wait_idle();
  endtask

  task automatic test_addr_change();
    int n;
    do_reset();
    set_addr(2, 3'd6);
    bus.req_i = 4'b0100;
    exp_q.push_back({3'd2, 3'd6});
    wait_en(1'b1, n);
    set_addr(2, 3'd1);
    bus.req_i = '0;
    wait_idle();
    checks++;
    if (sel_now() !== 3'd6) begin
      errors++;
      $display("FAIL addr_ignored: sel=%0d after access, required 6", sel_now());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    set_addr(1, 3'd3);
    set_addr(3, 3'd7);
    bus.req_i = 4'b0010;
    wait_en(1'b1, n);
    tick();
    rst_n = 1'b0;
    bus.req_i = 4'b1010;
    tick();
    checks++;
    if (bus.g1_en_o !== 1'b0 || bus.g2a_en_n_o !== 1'b1 || bus.g2b_en_n_o !== 1'b1
        || bus.grant_o !== '0 || bus.done_o !== '0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort: g1=%b g2a_n=%b g2b_n=%b grant=%b done=%b busy=%b, required 0/1/1/0000/0000/0",
               bus.g1_en_o, bus.g2a_en_n_o, bus.g2b_en_n_o, bus.grant_o, bus.done_o, bus.busy_o);
    end
    rst_n = 1'b1;
    exp_q.push_back({3'd1, 3'd3});
    tick();
    checks++;
    if (bus.grant_o !== 4'b0010 || sel_now() !== 3'd3) begin
      errors++;
      $display("FAIL abort_regrant: grant=%b sel=%0d, required 0010/3", bus.grant_o, sel_now());
    end
    bus.req_i = '0;
    wait_idle();
  endtask

  task automatic test_wrap();
    do_reset();
    set_addr(0, 3'd4);
    set_addr(2, 3'd2);
    bus.req_i = 4'b0100;
    exp_q.push_back({3'd2, 3'd2});
    tick();
    bus.req_i = '0;
    wait_idle();
    exp_q.push_back({3'd0, 3'd4});
    exp_q.push_back({3'd2, 3'd2});
    bus.req_i = 4'b0101;
    tick();
    checks++;
    if (bus.grant_o !== 4'b0001 || sel_now() !== 3'd4) begin
      errors++;
      $display("FAIL wrap_grant: grant=%b sel=%0d, required 0001/4", bus.grant_o, sel_now());
    end
    wait_drained();
    bus.req_i = '0;
    wait_idle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.req_i = '0;
    bus.addr_i = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_addr_change();
    test_reset_mid();
    test_wrap();
    repeat (5) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected completions never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
